// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - word selects and seven-segment codes shared by the io_output slice
package io_pkg;

    localparam logic [5:0] IO_OUT0_SEL = 6'b100000;
    localparam logic [5:0] IO_OUT1_SEL = 6'b100001;
    localparam logic [5:0] IO_OUT2_SEL = 6'b100010;
    localparam logic [5:0] IO_IN0_SEL  = 6'b100100;

    // Active-low g..a patterns for a common-anode digit
    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_NONE   = 8'hFF;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = SEG_HEX_0;
            4'h1:    code = SEG_HEX_1;
            4'h2:    code = SEG_HEX_2;
            4'h3:    code = SEG_HEX_3;
            4'h4:    code = SEG_HEX_4;
            4'h5:    code = SEG_HEX_5;
            4'h6:    code = SEG_HEX_6;
            4'h7:    code = SEG_HEX_7;
            4'h8:    code = SEG_HEX_8;
            4'h9:    code = SEG_HEX_9;
            4'hA:    code = SEG_HEX_A;
            4'hB:    code = SEG_HEX_B;
            4'hC:    code = SEG_HEX_C;
            4'hD:    code = SEG_HEX_D;
            4'hE:    code = SEG_HEX_E;
            default: code = SEG_HEX_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/io_output_if.sv
// rtl/io_output_if.sv - CPU store/readback bus into the memory-mapped output block
interface io_output_if;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        write_io_enable;
    logic [31:0] io_read_data;

    modport master (
        output addr,
        output datain,
        output write_io_enable,
        input  io_read_data
    );

    modport slave (
        input  addr,
        input  datain,
        input  write_io_enable,
        output io_read_data
    );
endinterface

// File: rtl/io_output_sevenseg.sv
// rtl/io_output_sevenseg.sv - scans a 32-bit value as 8 hex digits on a common-anode display
module io_output_sevenseg
    import io_pkg::*;
#(
    parameter int SCAN_DIV = 16
) (
    input  logic        io_clk,
    input  logic        reset,
    input  logic [31:0] value,
    output logic [7:0]  seg,
    output logic [7:0]  an
);

    localparam int CW = SCAN_DIV + 3;

    logic [CW-1:0] cnt;
    logic [2:0]    digit;
    logic [3:0]    nibble;

    // Top three counter bits pick the digit, so each digit is lit for 2**SCAN_DIV cycles
    assign digit  = cnt[CW-1:SCAN_DIV];
    assign nibble = value[{digit, 2'b00} +: 4];

    always_ff @(posedge io_clk) begin
        if (reset) begin
            cnt <= '0;
            seg <= SEG_BLANK;
            an  <= AN_NONE;
        end else begin
            cnt <= cnt + CW'(1);
            an  <= ~(8'b1 << digit);
            seg <= {1'b1, hex7(nibble)};
        end
    end

endmodule

// File: rtl/io_output.sv
// rtl/io_output.sv - memory-mapped output registers plus hex display; IO_OUT_READBACK_EN adds readback
module io_output
    import io_pkg::*;
#(
    parameter int SCAN_DIV = 16
) (
    input  logic        io_clk,
    input  logic        reset,
    io_output_if.slave  bus,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2,
    output logic [7:0]  seg,
    output logic [7:0]  an
);

    logic [5:0] sel;
    logic       unused_addr_bits;

    // Word-granular decode: byte offset and upper address bits never matter
    assign sel              = bus.addr[7:2];
    assign unused_addr_bits = ^{bus.addr[31:8], bus.addr[1:0]};

    always_ff @(posedge io_clk) begin
        if (reset) begin
            out_port0 <= '0;
            out_port1 <= '0;
            out_port2 <= '0;
        end else if (bus.write_io_enable) begin
            case (sel)
                IO_OUT0_SEL: out_port0 <= bus.datain;
                IO_OUT1_SEL: out_port1 <= bus.datain;
                IO_OUT2_SEL: out_port2 <= bus.datain;
                default: ;
            endcase
        end
    end

`ifdef IO_OUT_READBACK_EN
    always_comb begin
        bus.io_read_data = '0;
        case (sel)
            IO_OUT0_SEL: bus.io_read_data = out_port0;
            IO_OUT1_SEL: bus.io_read_data = out_port1;
            IO_OUT2_SEL: bus.io_read_data = out_port2;
            default:     bus.io_read_data = '0;
        endcase
    end
`else
    assign bus.io_read_data = '0;
`endif

    io_output_sevenseg #(
        .SCAN_DIV (SCAN_DIV)
    ) u_sevenseg (
        .io_clk (io_clk),
        .reset  (reset),
        .value  (out_port0),
        .seg    (seg),
        .an     (an)
    );

endmodule

// File: tb/tb_io_output.sv
// tb/tb_io_output.sv - scoreboard bench for io_output with a one-cycle-per-digit scan
module tb_io_output;

    logic        io_clk = 1'b0;
    logic        reset  = 1'b1;
    logic [31:0] out_port0, out_port1, out_port2;
    logic [7:0]  seg, an;

    io_output_if bus ();

    io_output #(
        .SCAN_DIV (0)
    ) dut (
        .io_clk    (io_clk),
        .reset     (reset),
        .bus       (bus),
        .out_port0 (out_port0),
        .out_port1 (out_port1),
        .out_port2 (out_port2),
        .seg       (seg),
        .an        (an)
    );

    always #5 io_clk = ~io_clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [2:0]  cnt_m    = '0;
    logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.exp);
        end
    endtask

    // Advance one clock; mirror the scan counter the DUT should be holding
    task automatic tick();
        logic r;
        r = reset;
        @(posedge io_clk);
        #1;
        cnt_m = r ? 3'd0 : cnt_m + 3'd1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic we);
        bus.addr            = a;
        bus.datain          = d;
        bus.write_io_enable = we;
        tick();
        bus.write_io_enable = 1'b0;
    endtask

    task automatic push_ports(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
        push("out_port0", p0);
        push("out_port1", p1);
        push("out_port2", p2);
    endtask

    task automatic pop_ports();
        pop_check(out_port0);
        pop_check(out_port1);
        pop_check(out_port2);
    endtask

    logic [31:0] p0_m, p1_m, p2_m, rb_exp;
    logic [31:0] scan_val;
    logic [2:0]  d;
    int          guard;

    initial begin
        bus.addr            = '0;
        bus.datain          = '0;
        bus.write_io_enable = 1'b0;
        p0_m = '0; p1_m = '0; p2_m = '0;

        // Reset for two cycles
        tick();
        tick();
        push_ports(0, 0, 0);
        push("rst_seg", 32'hFF);
        push("rst_an", 32'hFF);
        pop_ports();
        pop_check({24'h0, seg});
        pop_check({24'h0, an});

        reset = 1'b0;
        push("first_an", 32'hFE);
        push("first_seg", 32'hC0);
        tick();
        pop_check({24'h0, an});
        pop_check({24'h0, seg});

        // Back-to-back writes to the three ports
        wr(32'h80, 32'h12345678, 1'b1); p0_m = 32'h12345678;
        push_ports(p0_m, p1_m, p2_m); pop_ports();
        wr(32'h84, 32'hDEADBEEF, 1'b1); p1_m = 32'hDEADBEEF;
        push_ports(p0_m, p1_m, p2_m); pop_ports();
        wr(32'h88, 32'h000000A5, 1'b1); p2_m = 32'h000000A5;
        push_ports(p0_m, p1_m, p2_m); pop_ports();

        // Ignored writes: unmapped, input-port select, strobe low
        wr(32'h90, 32'hFFFFFFFF, 1'b1);
        wr(32'h8C, 32'hFFFFFFFF, 1'b1);
        wr(32'h84, 32'hFFFFFFFF, 1'b0);
        push_ports(p0_m, p1_m, p2_m); pop_ports();

        // Byte offset and high address bits are don't-care
        wr(32'h81, 32'h11112222, 1'b1); p0_m = 32'h11112222;
        push_ports(p0_m, p1_m, p2_m); pop_ports();
        wr(32'hABCD0187, 32'h33334444, 1'b1); p1_m = 32'h33334444;
        push_ports(p0_m, p1_m, p2_m); pop_ports();

        // Readback
        wr(32'h84, 32'h0000CAFE, 1'b1); p1_m = 32'h0000CAFE;
        bus.addr = 32'h84;
        #1;
`ifdef IO_OUT_READBACK_EN
        rb_exp = p1_m;
`else
        rb_exp = 32'h0;
`endif
        push("rb_84", rb_exp);
        pop_check(bus.io_read_data);
        bus.addr = 32'h90;
        #1;
        push("rb_90", 32'h0);
        pop_check(bus.io_read_data);
        bus.addr = 32'h80;
        #1;
`ifdef IO_OUT_READBACK_EN
        rb_exp = p0_m;
`else
        rb_exp = 32'h0;
`endif
        push("rb_80", rb_exp);
        pop_check(bus.io_read_data);

        // Scan through all digits and wrap, one digit per cycle
        scan_val = 32'hFEDCBA98;
        wr(32'h80, scan_val, 1'b1); p0_m = scan_val;
        for (int i = 0; i < 10; i++) begin
            d = cnt_m;
            push("scan_an", {24'h0, ~(8'h01 << d)});
            push("scan_seg", {24'h0, seg_tab[scan_val[d*4 +: 4]]});
            tick();
            pop_check({24'h0, an});
            pop_check({24'h0, seg});
        end

        // Reset mid-scan at digit 5
        wr(32'h84, 32'h5, 1'b1); p1_m = 32'h5;
        guard = 0;
        while (cnt_m != 3'd5 && guard < 16) begin
            tick();
            guard++;
        end
        push("reach_digit5", 32'd5);
        pop_check({29'h0, cnt_m});
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            push_ports(0, 0, 0);
            push("mid_rst_seg", 32'hFF);
            push("mid_rst_an", 32'hFF);
            pop_ports();
            pop_check({24'h0, seg});
            pop_check({24'h0, an});
        end
        reset = 1'b0;
        push("resume_an0", 32'hFE);
        push("resume_seg0", 32'hC0);
        tick();
        pop_check({24'h0, an});
        pop_check({24'h0, seg});
        push("resume_an1", 32'hFD);
        push("resume_seg1", 32'hC0);
        tick();
        pop_check({24'h0, an});
        pop_check({24'h0, seg});

        if (sb.size() != 0) check("scoreboard_leftover", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/io_output.md
Name: io_output

Overview:
- Memory-mapped output block; the write-side counterpart of the I/O input port.
- The CPU store path drives the address, data and a write enable. The block decodes addr[7:2] and latches data into three 32-bit output registers that feed LEDs and a GPIO header.
- It also time-multiplexes out_port0 as 8 hex digits onto an 8-digit common-anode seven-segment display.

Parameters:
- SCAN_DIV, 16: log2 of clock cycles per displayed digit. Counter width is SCAN_DIV+3. The value 0 is legal (bench use).

Ports:
- io_clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- addr  input  32  byte address from the CPU; only addr[7:2] is decoded.
- datain  input  32  store data.
- write_io_enable  input  1  store strobe; qualifies one write per asserted cycle.
- out_port0  output  32  register at word select 6'b100000 (0x80); also the display source.
- out_port1  output  32  register at 6'b100001 (0x84).
- out_port2  output  32  register at 6'b100010 (0x88).
- seg  output  8  active-low segments; seg[7]=dp, seg[6:0]=g..a.
- an  output  8  active-low digit enables; an[i] is hex digit i (digit 0 = out_port0[3:0]).
- io_read_data  output  32  readback data (see Optional Feature).

Behaviour:
- Reset (sync, dominant over everything): out_port0/1/2 = 0, scan counter = 0, seg = 8'hFF, an = 8'hFF.
- Write: at posedge with reset=0, write_io_enable=1 and a matching addr[7:2], the selected register takes datain. Visible the cycle after the edge (1-cycle latency).
- Write exclusions:
  - Writes to unmapped selects, including 6'b100100 (the input port), are ignored.
  - addr[1:0] and addr[31:8] are ignored. No byte enables; full-word writes only.
  - write_io_enable=0: all registers hold.
  - Back-to-back writes on consecutive cycles are each accepted.
- Scan counter: free-running SCAN_DIV+3 bits, +1 every cycle when not in reset, wraps from all-ones to 0. Digit index d = cnt[SCAN_DIV+2:SCAN_DIV].
- Display outputs (registered each cycle):
  - an = ~(8'b1 << d).
  - seg = {1'b1, hex7(out_port0[4d+3:4d])}.
  - seg/an therefore lag the counter and out_port0 by 1 cycle. The first valid digit appears 1 cycle after reset deasserts (an=8'hFE).
- hex7 (active-low g..a): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, B=03, C=46, D=21, E=06, F=0E. With dp added, 0 -> seg 8'hC0, 8 -> 8'h80, F -> 8'h8E.
- Write to out_port0 during a scan: the new nibble is shown on the first registered update after the register changes. There is no blanking.
- Reset mid-scan: the counter restarts at 0 and the display blanks for exactly the reset cycles.

Optional Feature:
- Macro: IO_OUT_READBACK_EN.
- Defined: io_read_data is a combinational mux on addr[7:2]: 0x80 -> out_port0, 0x84 -> out_port1, 0x88 -> out_port2, else 0. Readback does not depend on write_io_enable. A write in cycle N is readable from cycle N+1.
- Undefined: io_read_data is tied to 32'h0. The port is still present, so the top level is unchanged.

Decomposition:
- Shared package io_pkg:
  - word-select constants IO_OUT0_SEL=6'b100000, IO_OUT1_SEL=6'b100001, IO_OUT2_SEL=6'b100010, IO_IN0_SEL=6'b100100;
  - seven-segment code constants.
- One natural sub-module: io_output_sevenseg, containing the scan counter, digit select, hex7 decode and the seg/an registers. Its inputs are io_clk, reset and a 32-bit value.

Test Plan:
- Reset for 2 cycles -> out_port0/1/2 = 0, seg = FF, an = FF. One cycle after release: an = FE, seg = C0.
- Write 0x12345678 to addr 0x80, then 0xDEADBEEF to 0x84 on the next cycle, then 0xA5 to 0x88 -> the three ports hold those values, each updating the cycle after its strobe.
- Write 0xFFFFFFFF to 0x90, to 0x8C, and to 0x84 with write_io_enable=0 -> no register changes. Write to 0x81 (addr[1:0]=01) -> out_port0 is updated.
- SCAN_DIV=0, out_port0 = 0xFEDCBA98 -> over 8 cycles an steps FE, FD, FB, …, 7F with seg 80, 90, 88, 83, C6, A1, 86, 8E, then wraps to FE.
- Reset asserted while out_port1 = 0x5 and the scan is at digit 5 -> all ports are 0 and seg/an = FF during reset. The scan resumes at digit 0.
- With IO_OUT_READBACK_EN: addr 0x84 after writing 0xCAFE -> io_read_data = 0xCAFE; addr 0x90 -> 0. Without the macro: always 0.
